// File: rtl/seg_reader.sv
// Recovers per-digit BCD values from a multiplexed active-low 7-segment bus with stability filtering.
// Optional decimal-point tracking is enabled by defining SEG_READER_DP_EN.
module seg_reader #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
`ifdef SEG_READER_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_on,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic [2:0]              update_idx,
  output logic                    pattern_err,
  output logic                    sel_err,
  output logic                    err_sticky
);

`ifdef SEG_READER_DP_EN
  localparam int SEG_W = 8;
  logic [SEG_W-1:0] w_seg_in;
  assign w_seg_in = {dp, seg};
`else
  localparam int SEG_W = 7;
  logic [SEG_W-1:0] w_seg_in;
  assign w_seg_in = seg;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [SEG_W-1:0]        r_seg_p0, r_seg_p1;
  logic [NUM_DIGITS-1:0]   r_sel_p0, r_sel_p1;
  logic                    r_smp_vld;
  logic [3:0]              w_low_cnt;
  logic [2:0]              w_idx;
  logic                    w_legal, w_illegal, w_same, w_commit;
  logic [4:0]              w_dec;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic                    r_update, r_perr, r_sel_err, r_sticky;
  logic [2:0]              r_upd_idx;

  // Returns {recognised, value}; blank maps to value 4'hF, unknown patterns clear bit 4.
  function automatic logic [4:0] decode7(input logic [6:0] p);
    case (p)
      7'b1000000: decode7 = 5'h10;
      7'b1111001: decode7 = 5'h11;
      7'b0100100: decode7 = 5'h12;
      7'b0110000: decode7 = 5'h13;
      7'b0011001: decode7 = 5'h14;
      7'b0010010: decode7 = 5'h15;
      7'b0000010: decode7 = 5'h16;
      7'b1111000: decode7 = 5'h17;
      7'b0000000: decode7 = 5'h18;
      7'b0010000: decode7 = 5'h19;
      7'b1111111: decode7 = 5'h1F;
      default:    decode7 = 5'h0F;
    endcase
  endfunction

  // Stage p0: input sample; p1: previous sample. r_smp_vld keeps the all-zero reset sample from reading as a multi-select frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_p0  <= '0;
      r_sel_p0  <= '0;
      r_seg_p1  <= '0;
      r_sel_p1  <= '0;
      r_smp_vld <= 1'b0;
    end else begin
      r_seg_p0  <= w_seg_in;
      r_sel_p0  <= digit_sel;
      r_seg_p1  <= r_seg_p0;
      r_sel_p1  <= r_sel_p0;
      r_smp_vld <= 1'b1;
    end
  end

  always_comb begin
    w_low_cnt = 4'd0;
    w_idx     = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_sel_p0[i]) begin
        w_low_cnt = w_low_cnt + 4'd1;
        w_idx     = 3'(i);
      end
    end
  end

  assign w_legal   = r_smp_vld && (w_low_cnt == 4'd1);
  assign w_illegal = r_smp_vld && (w_low_cnt > 4'd1);
  assign w_same    = (r_seg_p0 == r_seg_p1) && (r_sel_p0 == r_sel_p1);
  assign w_dec     = decode7(r_seg_p0[6:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_legal) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (!w_legal) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (!w_same) begin
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          if (r_cnt != CNT_W'(STABLE_CNT)) w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(STABLE_CNT - 1)) begin
            w_commit    = 1'b1;
            w_state_nxt = HELD;
          end
        end
      end
      HELD: begin
        if (!w_legal) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (!w_same) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Stage p2: commit into the digit registers and raise the one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits  <= '1;
      r_valid   <= '0;
      r_update  <= 1'b0;
      r_upd_idx <= 3'd0;
      r_perr    <= 1'b0;
      r_sel_err <= 1'b0;
      r_sticky  <= 1'b0;
`ifdef SEG_READER_DP_EN
      dp_on     <= '0;
`endif
    end else begin
      r_update  <= 1'b0;
      r_perr    <= 1'b0;
      r_sel_err <= w_illegal;
      if (w_illegal) r_sticky <= 1'b1;
      if (w_commit) begin
        if (w_dec[4]) begin
          r_update  <= 1'b1;
          r_upd_idx <= w_idx;
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx == 3'(k)) begin
              r_digits[4*k +: 4] <= w_dec[3:0];
              r_valid[k]         <= (w_dec[3:0] != 4'hF);
`ifdef SEG_READER_DP_EN
              dp_on[k]           <= ~r_seg_p0[7];
`endif
            end
          end
        end else begin
          r_perr   <= 1'b1;
          r_sticky <= 1'b1;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign update      = r_update;
  assign update_idx  = r_upd_idx;
  assign pattern_err = r_perr;
  assign sel_err     = r_sel_err;
  assign err_sticky  = r_sticky;

endmodule

// File: tb/tb_seg_reader.sv
// Scoreboard bench for seg_reader: stimulus pushes expected commit events, a monitor pops them on update/pattern_err.
module tb_seg_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        update;
  logic [2:0]  update_idx;
  logic        pattern_err;
  logic        sel_err;
  logic        err_sticky;

  seg_reader #(.NUM_DIGITS(4), .STABLE_CNT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .seg(seg), .digit_sel(digit_sel),
    .digits(digits), .digit_valid(digit_valid), .update(update),
    .update_idx(update_idx), .pattern_err(pattern_err), .sel_err(sel_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;   // {pattern_err, update}
    logic [2:0]  idx;
    logic [15:0] dig;
    logic [3:0]  vld;
  } ev_t;

  ev_t         q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_selerr = 0;
  logic [15:0] m_dig = 16'hFFFF;
  logic [3:0]  m_vld = 4'h0;

  localparam logic [6:0] S0 = 7'b1000000, S2 = 7'b0100100, S3 = 7'b0110000,
                         S4 = 7'b0011001, S7 = 7'b1111000, S9 = 7'b0010000,
                         SBAD = 7'b0101010, SBLANK = 7'b1111111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] s, input int n);
    digit_sel = sel;
    seg       = s;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_update(input int idx, input logic [3:0] val);
    ev_t e;
    m_dig[idx*4 +: 4] = val;
    m_vld[idx]        = (val != 4'hF);
    e.kind = 2'b01; e.idx = 3'(idx); e.dig = m_dig; e.vld = m_vld;
    q.push_back(e);
  endtask

  task automatic exp_perr();
    ev_t e;
    e.kind = 2'b10; e.idx = 3'd0; e.dig = m_dig; e.vld = m_vld;
    q.push_back(e);
  endtask

  // Monitor: pops one expected event per presented output pulse.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sel_err) n_selerr++;
        if (update || pattern_err) begin
          if (q.size() == 0) begin
            chk("unexpected_event", {30'd0, pattern_err, update}, 32'd0);
          end else begin
            e = q.pop_front();
            chk("event_kind", {30'd0, pattern_err, update}, {30'd0, e.kind});
            if (e.kind == 2'b01) chk("update_idx", {29'd0, update_idx}, {29'd0, e.idx});
            chk("digits", {16'd0, digits}, {16'd0, e.dig});
            chk("digit_valid", {28'd0, digit_valid}, {28'd0, e.vld});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int sel_before;
    reset = 1'b1; digit_sel = 4'hF; seg = SBLANK;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", {16'd0, digits}, 32'h0000FFFF);
    chk("rst_valid", {28'd0, digit_valid}, 32'd0);
    chk("rst_update", {31'd0, update}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    reset = 1'b0;
    drive(4'hF, SBLANK, 3);

    // Basic commit of '2' on digit 0
    exp_update(0, 4'h2);
    drive(4'b1110, S2, 6);
    drive(4'hF, SBLANK, 3);
    chk("basic_digits", {16'd0, digits}, 32'h0000FFF2);
    chk("no_err_yet", {31'd0, err_sticky}, 32'd0);

    // Full scan 7,3,9,0
    exp_update(0, 4'h7); drive(4'b1110, S7, 8);
    exp_update(1, 4'h3); drive(4'b1101, S3, 8);
    exp_update(2, 4'h9); drive(4'b1011, S9, 8);
    exp_update(3, 4'h0); drive(4'b0111, S0, 8);
    drive(4'hF, SBLANK, 3);
    chk("scan_digits", {16'd0, digits}, 32'h00000937);
    chk("scan_valid", {28'd0, digit_valid}, 32'h0000000F);

    // Glitch rejection on digit 1: only the final 5-cycle window commits
    drive(4'b1101, S3, 2);
    drive(4'b1101, S4, 2);
    exp_update(1, 4'h3);
    drive(4'b1101, S3, 5);
    drive(4'hF, SBLANK, 3);
    chk("glitch_digit1", {28'd0, digits[7:4]}, 32'd3);

    // Unknown pattern on digit 2
    exp_perr();
    drive(4'b1011, SBAD, 6);
    drive(4'hF, SBLANK, 3);
    chk("perr_digit2", {28'd0, digits[11:8]}, 32'd9);
    chk("perr_sticky", {31'd0, err_sticky}, 32'd1);

    // Multi-select frames: one sel_err per cycle, no update
    sel_before = n_selerr;
    drive(4'b1100, S3, 5);
    drive(4'hF, SBLANK, 4);
    chk("selerr_count", 32'(n_selerr - sel_before), 32'd5);

    // Blank on digit 3
    exp_update(3, 4'hF);
    drive(4'b0111, SBLANK, 6);
    drive(4'hF, SBLANK, 4);
    chk("blank_digit3", {28'd0, digits[15:12]}, 32'hF);
    chk("queue_drained", 32'(q.size()), 32'd0);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_digits", {16'd0, digits}, 32'h0000FFFF);
    chk("async_rst_valid", {28'd0, digit_valid}, 32'd0);
    chk("async_rst_sticky", {31'd0, err_sticky}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
